quick_spi_scheduler: RTL and testbench

- Round-robin arbiter and sequencer that lets several on-chip requesters share one quick_spi master.
- Each requester names a target slave index.
- The block grants one requester, pulses the master's start, drives the one-hot slave select, and waits for the master's done.
- After done it enforces an inter-transaction guard gap, then re-arbitrates.
- Sits between client logic (sensor pollers, config loaders) and the SPI master.

---
 rtl/quick_spi_sched_pkg.sv | 22 ++
 rtl/quick_spi_scheduler_rr_arbiter.sv | 34 +++
 rtl/quick_spi_scheduler.sv | 154 +++++++++++++++
 tb/tb_quick_spi_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/quick_spi_sched_pkg.sv
// Shared types and constants for the quick_spi request scheduler.
package quick_spi_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        START  = 2'b01,
        ACTIVE = 2'b10,
        GUARD  = 2'b11
    } sched_state_e;

    localparam int DEF_GUARD_CYCLES   = 4;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    // Bits needed to index `value` items; never returns less than 1.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/quick_spi_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above rr_ptr, with wrap.
module rr_arbiter
    import quick_spi_sched_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4,
    localparam int PW = clog2(NUM_REQUESTERS)
) (
    input  logic [NUM_REQUESTERS-1:0] req,
    input  logic [PW-1:0]             rr_ptr,
    output logic [PW-1:0]             winner,
    output logic                      valid
);

    int            idx;
    logic [PW-1:0] sel;

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        sel    = '0;
        for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQUESTERS) idx = idx - NUM_REQUESTERS;
            sel = idx[PW-1:0];
            if (req[sel]) begin
                winner = sel;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/quick_spi_scheduler.sv
// Round-robin sequencer sharing one quick_spi master among several requesters.
// Optional watchdog on the ACTIVE phase: define QUICK_SPI_SCHED_TIMEOUT_EN.
module quick_spi_scheduler
    import quick_spi_sched_pkg::*;
#(
    parameter int NUM_REQUESTERS   = 4,
    parameter int NUMBER_OF_SLAVES = 2,
    parameter int SLAVE_IDX_W      = 4,
    parameter int GUARD_CYCLES     = DEF_GUARD_CYCLES,
    parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NUM_REQUESTERS-1:0]           req,
    input  logic [NUM_REQUESTERS*SLAVE_IDX_W-1:0] req_slave,
    output logic [NUM_REQUESTERS-1:0]           gnt,
    output logic [NUM_REQUESTERS-1:0]           done,
    output logic [NUM_REQUESTERS-1:0]           err,
    output logic                                spi_start,
    output logic [NUMBER_OF_SLAVES-1:0]         spi_slave,
    input  logic                                spi_done,
    output logic                                busy
);

    localparam int PW = clog2(NUM_REQUESTERS);
    localparam int GW = clog2(GUARD_CYCLES + 1);

    sched_state_e                  state, state_n;
    logic [PW-1:0]                 rr_ptr, rr_ptr_n;
    logic [PW-1:0]                 owner, owner_n;
    logic [PW-1:0]                 win;
    logic                          win_vld;
    logic [SLAVE_IDX_W-1:0]        win_slave;
    logic [GW-1:0]                 guard_cnt, guard_cnt_n;
    logic [NUM_REQUESTERS-1:0]     gnt_n, done_n, err_n;
    logic                          start_n;
    logic [NUMBER_OF_SLAVES-1:0]   slave_n;
    logic                          complete, fail;
`ifdef QUICK_SPI_SCHED_TIMEOUT_EN
    logic [31:0]                   wdog, wdog_n;
`endif

    rr_arbiter #(.NUM_REQUESTERS(NUM_REQUESTERS)) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (win),
        .valid  (win_vld)
    );

    always_comb begin
        state_n     = state;
        rr_ptr_n    = rr_ptr;
        owner_n     = owner;
        guard_cnt_n = guard_cnt;
        gnt_n       = gnt;
        done_n      = '0;
        err_n       = '0;
        start_n     = 1'b0;
        slave_n     = spi_slave;
        complete    = 1'b0;
        fail        = 1'b0;
        win_slave   = req_slave[win*SLAVE_IDX_W +: SLAVE_IDX_W];
`ifdef QUICK_SPI_SCHED_TIMEOUT_EN
        wdog_n      = wdog;
`endif
        case (state)
            IDLE: begin
                if (win_vld) begin
                    owner_n  = win;
                    rr_ptr_n = (int'(win) == NUM_REQUESTERS - 1) ? '0 : win + 1'b1;
                    if (int'(win_slave) < NUMBER_OF_SLAVES) begin
                        gnt_n   = NUM_REQUESTERS'(1) << win;
                        slave_n = NUMBER_OF_SLAVES'(1) << win_slave;
                        start_n = 1'b1;
                        state_n = START;
`ifdef QUICK_SPI_SCHED_TIMEOUT_EN
                        wdog_n  = '0;
`endif
                    end else begin
                        // Unreachable slave: answer the client directly with an error.
                        done_n      = NUM_REQUESTERS'(1) << win;
                        err_n       = NUM_REQUESTERS'(1) << win;
                        guard_cnt_n = '0;
                        state_n     = (GUARD_CYCLES == 0) ? IDLE : GUARD;
                    end
                end
            end
            START: begin
                if (spi_done) complete = 1'b1;
                else          state_n  = ACTIVE;
            end
            ACTIVE: begin
                if (spi_done) begin
                    complete = 1'b1;
                end
`ifdef QUICK_SPI_SCHED_TIMEOUT_EN
                else if (wdog == 32'(TIMEOUT_CYCLES - 1)) begin
                    complete = 1'b1;
                    fail     = 1'b1;
                end else begin
                    wdog_n = wdog + 32'd1;
                end
`endif
            end
            GUARD: begin
                if (guard_cnt == GW'(GUARD_CYCLES - 1)) state_n     = IDLE;
                else                                    guard_cnt_n = guard_cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase

        if (complete) begin
            gnt_n       = '0;
            slave_n     = '0;
            done_n      = NUM_REQUESTERS'(1) << owner;
            err_n       = fail ? (NUM_REQUESTERS'(1) << owner) : '0;
            guard_cnt_n = '0;
            state_n     = (GUARD_CYCLES == 0) ? IDLE : GUARD;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            guard_cnt <= '0;
            gnt       <= '0;
            done      <= '0;
            err       <= '0;
            spi_start <= 1'b0;
            spi_slave <= '0;
            busy      <= 1'b0;
`ifdef QUICK_SPI_SCHED_TIMEOUT_EN
            wdog      <= '0;
`endif
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_ptr_n;
            owner     <= owner_n;
            guard_cnt <= guard_cnt_n;
            gnt       <= gnt_n;
            done      <= done_n;
            err       <= err_n;
            spi_start <= start_n;
            spi_slave <= slave_n;
            busy      <= (state_n != IDLE);
`ifdef QUICK_SPI_SCHED_TIMEOUT_EN
            wdog      <= wdog_n;
`endif
        end
    end

endmodule

// File: tb/tb_quick_spi_scheduler.sv
// Self-checking bench for quick_spi_scheduler against a transaction-level rotation model.
module tb_quick_spi_scheduler;

    localparam int N  = 4;
    localparam int NS = 2;
    localparam int SW = 4;
    localparam int G  = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*SW-1:0] req_slave = '0;
    logic            spi_done = 1'b0;
    logic [N-1:0]    gnt, done, err;
    logic            spi_start;
    logic [NS-1:0]   spi_slave;
    logic            busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rr_m = 0;
    int last_start = -100;
    int slv_m [N];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    quick_spi_scheduler #(
        .NUM_REQUESTERS(N), .NUMBER_OF_SLAVES(NS), .SLAVE_IDX_W(SW),
        .GUARD_CYCLES(G), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_slave(req_slave),
        .gnt(gnt), .done(done), .err(err), .spi_start(spi_start),
        .spi_slave(spi_slave), .spi_done(spi_done), .busy(busy)
    );

    initial begin
        #100000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_slv(input int i, input int v);
        slv_m[i] = v;
        req_slave[i*SW +: SW] = v[SW-1:0];
    endtask

    // Reference arbitration: first pending index at or above ptr, wrapping.
    function automatic int pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++)
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    // One full transaction from IDLE to the next IDLE cycle, checked against the model.
    task automatic serve(input int dly, input bit drop, output int w, output int lat);
        int s;
        int n;
        w = pick(req, rr_m);
        s = (w >= 0) ? slv_m[w] : 0;
        n = 0;
        while (gnt == '0 && done == '0 && n < 20) begin
            tick();
            n++;
        end
        lat = n;
        chk("arb_wait_bound", (n < 20), 1);
        rr_m = (w + 1) % N;
        if (s < NS) begin
            chk("gnt_onehot", gnt, 1 << w);
            chk("spi_start_pulse", spi_start, 1);
            chk("spi_slave_sel", spi_slave, 1 << s);
            chk("busy_start", busy, 1);
            chk("no_done_at_start", done, 0);
            if (last_start >= 0) chk("start_gap", (cyc - last_start >= G + 2), 1);
            last_start = cyc;
            for (int k = 0; k < dly; k++) begin
                tick();
                chk("gnt_held", gnt, 1 << w);
                chk("start_dropped", spi_start, 0);
                chk("slave_held", spi_slave, 1 << s);
            end
            spi_done = 1'b1;
            tick();
            spi_done = 1'b0;
            chk("done_pulse", done, 1 << w);
            chk("err_clear", err, 0);
            chk("gnt_released", gnt, 0);
            chk("slave_released", spi_slave, 0);
        end else begin
            chk("inv_done", done, 1 << w);
            chk("inv_err", err, 1 << w);
            chk("inv_no_start", spi_start, 0);
            chk("inv_no_gnt", gnt, 0);
        end
        if (drop) req[w] = 1'b0;
        for (int k = 1; k < G; k++) begin
            tick();
            chk("guard_busy", busy, 1);
            chk("guard_quiet", {gnt, done, spi_start}, 0);
        end
        tick();
        chk("idle_not_busy", busy, 0);
    endtask

    initial begin
        int w;
        int lat;
        int n;
        for (int i = 0; i < N; i++) set_slv(i, 0);

        // Reset state
        tick(); tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_start", spi_start, 0);
        chk("rst_slave", spi_slave, 0);
        chk("rst_busy", busy, 0);

        // Single requester, slave 1, completion 5 cycles after start
        reset_n = 1'b1;
        set_slv(0, 1);
        req = 4'b0001;
        serve(5, 1'b1, w, lat);
        chk("single_winner", w, 0);
        chk("single_latency", lat, 1);

        // Reset in the middle of ACTIVE aborts without a done
        set_slv(2, 0);
        req = 4'b0100;
        n = 0;
        while (gnt == '0 && n < 20) begin tick(); n++; end
        chk("abort_grant_seen", gnt, 4'b0100);
        tick(); tick();
        reset_n = 1'b0;
        spi_done = 1'b1;
        tick();
        chk("abort_gnt", gnt, 0);
        chk("abort_slave", spi_slave, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        tick();
        chk("abort_done_late", done | err, 0);
        spi_done = 1'b0;
        rr_m = 0;
        last_start = -100;

        // All four pending: strict rotation from a freshly reset pointer
        for (int i = 0; i < N; i++) set_slv(i, i % NS);
        req = 4'b1111;
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            serve(1 + k, 1'b0, w, lat);
            chk("rotation_order", w, k % N);
        end
        req = '0;

        // Invalid slave index on requester 2, requester 3 served next
        set_slv(2, 5);
        set_slv(3, 1);
        req = 4'b1100;
        serve(2, 1'b1, w, lat);
        chk("invalid_winner", w, 2);
        serve(3, 1'b1, w, lat);
        chk("after_invalid_winner", w, 3);

        // Completion signalled in the START cycle
        set_slv(0, 0);
        req = 4'b0001;
        serve(0, 1'b1, w, lat);
        chk("start_done_winner", w, 0);

        // Randomized traffic against the rotation model
        for (int it = 0; it < 40; it++) begin
            logic [N-1:0] add;
            add = 4'($urandom_range(0, 15)) & ~req;
            if ((req | add) == '0) add = 4'(1 << $urandom_range(0, N - 1));
            for (int i = 0; i < N; i++)
                if (add[i]) set_slv(i, $urandom_range(0, 2));
            req = req | add;
            serve($urandom_range(0, 4), 1'b1, w, lat);
        end
        req = '0;

`ifdef QUICK_SPI_SCHED_TIMEOUT_EN
        // Master never answers: watchdog completes with an error
        set_slv(1, 0);
        req = 4'b0010;
        tick();
        chk("to_grant", gnt, 4'b0010);
        n = 0;
        while (done == '0 && n < 40) begin tick(); n++; end
        chk("to_latency", n, TO + 1);
        chk("to_done", done, 4'b0010);
        chk("to_err", err, 4'b0010);
        chk("to_gnt_clear", gnt, 0);
        req = '0;
        for (int k = 1; k < G; k++) tick();
        tick();
        chk("to_back_idle", busy, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
